seg_p2s_ctrl: RTL and testbench
===============================

SEG_P2S_CTRL -- requirements
Module: seg_p2s_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 64, SHALL set the frame width (8..256); one bit per serial clock.
REQ-002 Parameter CLK_DIV, default 2, SHALL set each serial-clock half-period in clk cycles (1..255).
REQ-003 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a frame transfer; it is sampled only in IDLE.
REQ-006 p_data  input  DATA_BITS  SHALL be the parallel frame, captured on accept.
REQ-007 busy  output  1  SHALL be high while a frame is in progress.
REQ-008 done  output  1  SHALL be a one-cycle completion pulse.
REQ-009 s_clk  output  1  SHALL be the serial clock to the downstream shift-register chain.
REQ-010 s_data  output  1  SHALL be the serial data bit, MSB of the frame first.
REQ-011 s_latch  output  1  SHALL be the frame-complete strobe to the downstream chain.

Function
REQ-012 FSM states SHALL be IDLE, LOW, HIGH, LATCH and FIN.
REQ-013 IDLE with start=1 at edge k SHALL load p_data into an internal shadow register, load bit count = DATA_BITS, and enter LOW with busy=1 from cycle k+1.
REQ-014 start while busy=1 SHALL be ignored; p_data changes after accept SHALL have no effect.
REQ-015 s_data SHALL equal shadow[DATA_BITS-1] at all times; it SHALL change only on the LOW entry edge, so it is stable for CLK_DIV cycles before every s_clk rising edge.
REQ-016 LOW SHALL drive s_clk=0 for CLK_DIV cycles, then enter HIGH.
REQ-017 HIGH SHALL drive s_clk=1 for CLK_DIV cycles, then shift shadow left by one (zero fill) and decrement count.
REQ-018 On leaving HIGH, the next state SHALL be LOW if the decremented count is nonzero, and LATCH otherwise.
REQ-019 LATCH SHALL drive s_clk=0 and s_latch=1 for CLK_DIV cycles, then enter FIN.
REQ-020 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 done SHALL be asserted exactly 2*CLK_DIV*DATA_BITS + CLK_DIV + 1 cycles after the accepting edge.
REQ-022 start=1 during FIN SHALL be ignored; start=1 in the first IDLE cycle after FIN SHALL be accepted, so the minimum start-to-start period is that latency plus 1.
REQ-023 Exactly DATA_BITS s_clk rising edges SHALL occur per frame.
REQ-024 The phase counter SHALL be ceil(log2(CLK_DIV+1)) bits, and the bit counter SHALL be ceil(log2(DATA_BITS+1)) bits; neither SHALL wrap.
REQ-025 All outputs SHALL be registered, with no combinational path from start or p_data.

Reset
REQ-026 rst=1 at any edge, including mid-frame, SHALL force the following at the next edge: IDLE, busy=0, done=0, s_clk=0, s_data=0, s_latch=0, shadow=0, counters=0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 A frame aborted by reset SHALL NOT produce s_latch or done.

Structure
REQ-029 Package seg_p2s_pkg SHALL hold the state enum and the default DATA_BITS and CLK_DIV constants.
REQ-030 The half-period timer SHALL be sub-module p2s_phase_timer (inputs clk, rst, restart; output expire); the FSM, shadow register and bit counter SHALL stay in seg_p2s_ctrl.

Verification (DATA_BITS=8, CLK_DIV=2)
REQ-031 Frame test: reset, then start with p_data=8'hA5 -> s_data sampled at the 8 s_clk rising edges = 1,0,1,0,0,1,0,1, s_latch high 2 cycles, done at accept+35.
REQ-032 Busy test: start with 8'hFF, pulse start with 8'h00 at accept+10 -> second request ignored, all 8 bits 1, a single done.
REQ-033 Mid-frame reset: rst=1 at accept+12 -> all outputs 0 next cycle, no s_latch, no done; a subsequent start with 8'h3C transfers correctly.
REQ-034 Back-to-back: start held high continuously with 8'h81 -> frames 36 cycles apart, each with 8 rising edges and one done.
REQ-035 Parameter sweep: DATA_BITS=64, CLK_DIV=1, p_data=64'h0123_4567_89AB_CDEF -> serial stream matches MSB-first, done at accept+130.

Source files
------------

// File: rtl/seg_p2s_pkg.sv
// seg_p2s_pkg: shared state encoding and default geometry for the serialiser
package seg_p2s_pkg;
  localparam int DEF_DATA_BITS = 64;
  localparam int DEF_CLK_DIV = 2;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, LATCH, FIN} state_t;
endpackage

// File: rtl/p2s_phase_timer.sv
// p2s_phase_timer: half-period timer, expire on the CLK_DIV-th cycle after restart
module p2s_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);
  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] TOP = W'(CLK_DIV);
  logic [W-1:0] cnt;
  assign expire = cnt == LAST;
  // saturates at CLK_DIV so an idle timer never wraps
  always_ff @(posedge clk)
    if (rst || restart) cnt <= '0;
    else if (cnt != TOP) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seg_p2s_ctrl.sv
// seg_p2s_ctrl: MSB-first parallel-to-serial driver for a shift-register chain
module seg_p2s_ctrl
  import seg_p2s_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] p_data,
  output logic                 busy,
  output logic                 done,
  output logic                 s_clk,
  output logic                 s_data,
  output logic                 s_latch
);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state;
  logic [DATA_BITS-1:0] shadow;
  logic [CW-1:0] count;
  logic expire, restart;
  // the timer idles cleared so the first LOW phase is a full CLK_DIV cycles
  assign restart = state == IDLE || state == FIN || expire;
  p2s_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk(clk), .rst(rst), .restart(restart), .expire(expire)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_data  <= 1'b0;
      s_latch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= LOW;
          shadow <= p_data;
          count  <= CW'(DATA_BITS);
          busy   <= 1'b1;
          s_data <= p_data[DATA_BITS-1];
        end
        LOW: if (expire) begin
          state <= HIGH;
          s_clk <= 1'b1;
        end
        HIGH: if (expire) begin
          state   <= count == ONE ? LATCH : LOW;
          s_latch <= count == ONE;
          s_clk   <= 1'b0;
          shadow  <= shadow << 1;
          s_data  <= shadow[DATA_BITS-2];
          count   <= count - 1'b1;
        end
        LATCH: if (expire) begin
          state   <= FIN;
          s_latch <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seg_p2s_ctrl.sv
// tb_seg_p2s_ctrl: scoreboard bench for an 8-bit/div-2 and a 64-bit/div-1 instance
module tb_seg_p2s_ctrl;
  typedef struct {
    logic [63:0] data;
    int nbits;
    int lat;
    int latch;
    int gap;
    bit abort;
  } exp_t;
  logic clk = 0;
  logic rst_a = 1, start_a = 0, rst_b = 1, start_b = 0;
  logic [7:0] p_data_a = 0;
  logic [63:0] p_data_b = 0;
  logic busy_a, done_a, s_clk_a, s_data_a, s_latch_a;
  logic busy_b, done_b, s_clk_b, s_data_b, s_latch_b;
  int cyc = 0, chk = 0, err = 0;
  exp_t sb[2][$];
  exp_t cur[2];
  bit prev_sclk[2], prev_busy[2], in_frame[2];
  int acc[2], last_acc[2], bidx[2], lcnt[2];

  seg_p2s_ctrl #(.DATA_BITS(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .p_data(p_data_a), .busy(busy_a),
    .done(done_a), .s_clk(s_clk_a), .s_data(s_data_a), .s_latch(s_latch_a)
  );
  seg_p2s_ctrl #(.DATA_BITS(64), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .p_data(p_data_b), .busy(busy_b),
    .done(done_b), .s_clk(s_clk_b), .s_data(s_data_b), .s_latch(s_latch_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ck(string n, longint a, longint e);
    chk++;
    if (a !== e) begin
      err++;
      $display("FAIL %s act=%0d exp=%0d @cyc %0d", n, a, e, cyc);
    end
  endfunction

  task automatic mon(input int i, input logic busy, done, sclk, sdata, slatch);
    if (busy && !prev_busy[i]) begin
      ck("frame_expected", sb[i].size() > 0, 1);
      if (sb[i].size() > 0) begin
        cur[i] = sb[i].pop_front();
        acc[i] = cyc - 1;
        if (cur[i].gap > 0) ck("start_gap", acc[i] - last_acc[i], cur[i].gap);
        last_acc[i] = acc[i];
        bidx[i] = 0;
        lcnt[i] = 0;
        in_frame[i] = 1;
      end
    end
    if (in_frame[i] && sclk && !prev_sclk[i]) begin
      if (bidx[i] < cur[i].nbits) ck("s_data_bit", sdata, cur[i].data[cur[i].nbits-1-bidx[i]]);
      bidx[i]++;
    end
    if (slatch) lcnt[i]++;
    if (done) begin
      ck("done_in_frame", in_frame[i], 1);
      if (in_frame[i]) begin
        ck("done_not_aborted", cur[i].abort, 0);
        ck("done_latency", cyc - acc[i], cur[i].lat);
        ck("rising_edges", bidx[i], cur[i].nbits);
        ck("latch_cycles", lcnt[i], cur[i].latch);
        ck("busy_at_done", busy, 0);
      end
      in_frame[i] = 0;
    end else if (prev_busy[i] && !busy) begin
      ck("abort_expected", cur[i].abort, 1);
      ck("abort_outputs", {sclk, sdata, slatch}, 0);
      ck("abort_no_latch", lcnt[i], 0);
      in_frame[i] = 0;
    end
    prev_sclk[i] = sclk;
    prev_busy[i] = busy;
  endtask

  always @(negedge clk) begin
    mon(0, busy_a, done_a, s_clk_a, s_data_a, s_latch_a);
    mon(1, busy_b, done_b, s_clk_b, s_data_b, s_latch_b);
  end

  task automatic go_a(input logic [7:0] d, input bit abort);
    exp_t e;
    e = '{data: {56'd0, d}, nbits: 8, lat: 35, latch: 2, gap: 0, abort: abort};
    @(negedge clk);
    sb[0].push_back(e);
    start_a = 1;
    p_data_a = d;
    @(negedge clk);
    start_a = 0;
    p_data_a = ~d;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst_a = 0;
    rst_b = 0;
    ck("rst_busy", busy_a, 0);
    ck("rst_done", done_a, 0);
    ck("rst_s_clk", s_clk_a, 0);
    ck("rst_s_data", s_data_a, 0);
    ck("rst_s_latch", s_latch_a, 0);
    ck("rst_b_outputs", {busy_b, done_b, s_clk_b, s_data_b, s_latch_b}, 0);
    go_a(8'hA5, 0);
    repeat (40) @(negedge clk);
    go_a(8'hFF, 0);
    repeat (9) @(negedge clk);
    start_a = 1;
    p_data_a = 8'h00;
    @(negedge clk);
    start_a = 0;
    repeat (40) @(negedge clk);
    go_a(8'h5A, 1);
    repeat (10) @(negedge clk);
    rst_a = 1;
    start_a = 1;
    @(negedge clk);
    rst_a = 0;
    start_a = 0;
    ck("rst_mid_busy", busy_a, 0);
    repeat (5) @(negedge clk);
    go_a(8'h3C, 0);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = '{data: 64'h81, nbits: 8, lat: 35, latch: 2, gap: k == 0 ? 0 : 36, abort: 0};
      sb[0].push_back(e);
    end
    start_a = 1;
    p_data_a = 8'h81;
    repeat (74) @(negedge clk);
    start_a = 0;
    repeat (40) @(negedge clk);
    e = '{data: 64'h0123_4567_89AB_CDEF, nbits: 64, lat: 130, latch: 1, gap: 0, abort: 0};
    sb[1].push_back(e);
    start_b = 1;
    p_data_b = e.data;
    @(negedge clk);
    start_b = 0;
    p_data_b = '0;
    repeat (140) @(negedge clk);
    ck("sb_a_drained", sb[0].size(), 0);
    ck("sb_b_drained", sb[1].size(), 0);
    ck("a_idle", in_frame[0], 0);
    ck("b_idle", in_frame[1], 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
